// File: rtl/jtag_host_driver.sv
// -----------------------------------------------------------------------------
// jtag_host_driver
//   JTAG TAP initiator. A command accepted on the valid/ready interface walks
//   the target TAP from Run-Test/Idle into Shift-IR/Shift-DR and back, or runs
//   a Test-Logic-Reset or idle sequence. Up to DATA_W bits are shifted
//   LSB-first, and TDO is captured into rsp_data.
//
//   Each TCK slot has two halves of CLK_DIV clk each. The slot's tms/tdi
//   values are driven on the accept edge or on the preceding fall edge. tdo is
//   sampled on the clk edge that raises tck.
//
//   Optional feature macro: JTAG_HOST_TRST_EN. When it is defined, the module
//   adds the trst_n output and drives it low for the duration of a RESET op.
//
// Ports
//   clk, rst_n           system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake (cmd_ready = host idle)
//   cmd_op               0=RESET 1=SHIFT_IR 2=SHIFT_DR 3=IDLE
//   cmd_len              shift bit count (SHIFT_*) or TCK count (IDLE)
//   cmd_data             TDI bits, bit i at shift position i
//   rsp_valid/rsp_data   1-cycle completion pulse, captured TDO (held)
//   busy                 ~cmd_ready
//   tck, tms, tdi        registered JTAG outputs
//   trst_n               (JTAG_HOST_TRST_EN only) TAP reset, active low
//   tdo                  JTAG data from the target
// -----------------------------------------------------------------------------
module jtag_host_driver #(
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 6,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              tck,
  output logic              tms,
  output logic              tdi,
`ifdef JTAG_HOST_TRST_EN
  output logic              trst_n,
`endif
  input  logic              tdo
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [1:0] OP_RESET = 2'd0;
  localparam logic [1:0] OP_IR    = 2'd1;
  localparam logic [1:0] OP_DR    = 2'd2;
  localparam logic [1:0] OP_IDLE  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_HEAD, S_SHIFT, S_TAIL} state_t;

  state_t              state_q, state_n;
  logic [LEN_W-1:0]    cnt_q, cnt_n;
  logic [LEN_W:0]      cnt_inc;
  logic [DIV_W-1:0]    div_q;
  logic                tck_q, tms_q, tdi_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_data_q;

  // Per-command registers. These are loaded on accept and need no reset.
  logic [1:0]          op_q;
  logic [LEN_W-1:0]    len_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   cap_q;

  logic                tick, accept, rise, fall, done;
  logic [1:0]          op_sel;
  logic [LEN_W-1:0]    len_sel;
  logic [DATA_W-1:0]   data_sel;
  logic                nxt_tms, nxt_tdi;

  // Effective shift length: 0 means 1 bit, and values above DATA_W are clamped.
  function automatic logic [LEN_W-1:0] shift_len(input logic [LEN_W-1:0] len);
    if (len == '0)
      shift_len = {{(LEN_W-1){1'b0}}, 1'b1};
    else if (int'(len) > DATA_W)
      shift_len = LEN_W'(DATA_W);
    else
      shift_len = len;
  endfunction

  // Number of head slots for each op. An IDLE op consists of head slots only.
  function automatic logic [LEN_W-1:0] head_len(input logic [1:0] op,
                                                input logic [LEN_W-1:0] len);
    case (op)
      OP_RESET: head_len = LEN_W'(6);
      OP_IR:    head_len = LEN_W'(4);
      OP_DR:    head_len = LEN_W'(3);
      default:  head_len = len;
    endcase
  endfunction

  function automatic logic slot_tms(input state_t st, input logic [1:0] op,
                                    input logic [LEN_W-1:0] cnt,
                                    input logic [LEN_W-1:0] len);
    slot_tms = 1'b0;
    case (st)
      S_HEAD: begin
        case (op)
          OP_RESET: slot_tms = (cnt < LEN_W'(5));   // 1,1,1,1,1,0
          OP_IR:    slot_tms = (cnt < LEN_W'(2));   // 1,1,0,0
          OP_DR:    slot_tms = (cnt == '0);         // 1,0,0
          default:  slot_tms = 1'b0;
        endcase
      end
      S_SHIFT: slot_tms = (cnt == len - 1'b1);      // leave Shift on the last bit
      S_TAIL:  slot_tms = (cnt == '0);              // Update, then Run-Test/Idle
      default: slot_tms = 1'b0;
    endcase
  endfunction

  function automatic logic bit_at(input logic [DATA_W-1:0] data,
                                  input logic [LEN_W-1:0] idx);
    bit_at = 1'b0;
    for (int i = 0; i < DATA_W; i++)
      if (LEN_W'(i) == idx) bit_at = data[i];
  endfunction

  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    accept   = 1'b0;
    rise     = 1'b0;
    fall     = 1'b0;
    done     = 1'b0;
    op_sel   = op_q;
    len_sel  = len_q;
    data_sel = data_q;
    nxt_tms  = tms_q;
    nxt_tdi  = tdi_q;
    tick     = (div_q == DIV_LAST);
    cnt_inc  = {1'b0, cnt_q} + {{LEN_W{1'b0}}, 1'b1};

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          accept   = 1'b1;
          op_sel   = cmd_op;
          data_sel = cmd_data;
          len_sel  = (cmd_op == OP_IDLE) ? cmd_len : shift_len(cmd_len);
          cnt_n    = '0;
          if (cmd_op == OP_IDLE && cmd_len == '0)
            done = 1'b1;
          else
            state_n = S_HEAD;
        end
      end
      default: begin
        if (tick) begin
          if (!tck_q) begin
            rise = 1'b1;
          end else begin
            // A fall edge ends the current slot. Advance to the next slot.
            fall = 1'b1;
            case (state_q)
              S_HEAD: begin
                if (cnt_inc < {1'b0, head_len(op_q, len_q)})
                  cnt_n = cnt_inc[LEN_W-1:0];
                else if (op_q == OP_IR || op_q == OP_DR) begin
                  state_n = S_SHIFT;
                  cnt_n   = '0;
                end else
                  done = 1'b1;
              end
              S_SHIFT: begin
                if (cnt_inc < {1'b0, len_q})
                  cnt_n = cnt_inc[LEN_W-1:0];
                else begin
                  state_n = S_TAIL;
                  cnt_n   = '0;
                end
              end
              default: begin
                if (cnt_q == '0)
                  cnt_n = {{(LEN_W-1){1'b0}}, 1'b1};
                else
                  done = 1'b1;
              end
            endcase
          end
        end
      end
    endcase

    if (done) begin
      state_n = S_IDLE;
      cnt_n   = '0;
      nxt_tms = 1'b0;
      nxt_tdi = 1'b0;
    end else if (accept || fall) begin
      nxt_tms = slot_tms(state_n, op_sel, cnt_n, len_sel);
      nxt_tdi = (state_n == S_SHIFT) ? bit_at(data_sel, cnt_n) : 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      div_q       <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      if (accept)
        div_q <= '0;
      else if (state_q != S_IDLE)
        div_q <= tick ? '0 : div_q + 1'b1;
      if (rise)
        tck_q <= 1'b1;
      else if (fall)
        tck_q <= 1'b0;
      tms_q       <= nxt_tms;
      tdi_q       <= nxt_tdi;
      rsp_valid_q <= done;
      if (done)
        rsp_data_q <= (!accept && (op_q == OP_IR || op_q == OP_DR)) ? cap_q : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= cmd_op;
      len_q  <= len_sel;
      data_q <= cmd_data;
      cap_q  <= '0;
    end else if (rise && state_q == S_SHIFT) begin
      for (int i = 0; i < DATA_W; i++)
        if (LEN_W'(i) == cnt_q) cap_q[i] <= tdo;
    end
  end

`ifdef JTAG_HOST_TRST_EN
  logic trst_q;
  logic trst_hold;

  // trst_n is held low from the RESET accept edge through the final fall edge.
  assign trst_hold = (state_n != S_IDLE) && (op_sel == OP_RESET);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      trst_q <= 1'b0;
    else
      trst_q <= ~trst_hold;
  end

  assign trst_n = trst_q;
`endif

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = ~cmd_ready;
  assign tck       = tck_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_jtag_host_driver.sv
// -----------------------------------------------------------------------------
// tb_jtag_host_driver
//   Directed bench for jtag_host_driver. A behavioural TAP target provides an
//   IR capture value of 4'b0001 and an IDCODE of 0xDEADBEEF. Every rising edge
//   of tck is logged, so that the TMS and TDI sequences can be compared against
//   hand-computed vectors.
// -----------------------------------------------------------------------------
module tb_jtag_host_driver;

  localparam int DATA_W  = 32;
  localparam int LEN_W   = 6;
  localparam int CLK_DIV = 2;
  localparam logic [31:0] IDCODE = 32'hDEADBEEF;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic [1:0]        cmd_op = 2'd0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic              cmd_ready, rsp_valid, busy, tck, tms, tdi;
  logic [DATA_W-1:0] rsp_data;
  logic              tdo = 1'b0;
`ifdef JTAG_HOST_TRST_EN
  logic              trst_n;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int lat;
  int trst_low;
  logic [DATA_W-1:0] rsp;

  jtag_host_driver #(.DATA_W(DATA_W), .LEN_W(LEN_W), .CLK_DIV(CLK_DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .tck       (tck),
    .tms       (tms),
    .tdi       (tdi),
`ifdef JTAG_HOST_TRST_EN
    .trst_n    (trst_n),
`endif
    .tdo       (tdo)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural TAP target ----------------
  typedef enum logic [3:0] {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PAUDR, EX2DR,
                            UPDR, SELIR, CAPIR, SHIR, EX1IR, PAUIR, EX2IR, UPIR} tap_t;
  tap_t        tap = SHDR;          // arbitrary state before the first RESET
  logic [31:0] dr_sr = '0;
  logic [3:0]  ir_sr = '0;
  logic [3:0]  ir_reg = '0;
  logic        tms_log[$];
  logic        tdi_log[$];

  function automatic tap_t tap_next(input tap_t s, input logic m);
    case (s)
      TLR:     return m ? TLR   : RTI;
      RTI:     return m ? SELDR : RTI;
      SELDR:   return m ? SELIR : CAPDR;
      CAPDR:   return m ? EX1DR : SHDR;
      SHDR:    return m ? EX1DR : SHDR;
      EX1DR:   return m ? UPDR  : PAUDR;
      PAUDR:   return m ? EX2DR : PAUDR;
      EX2DR:   return m ? UPDR  : SHDR;
      UPDR:    return m ? SELDR : RTI;
      SELIR:   return m ? TLR   : CAPIR;
      CAPIR:   return m ? EX1IR : SHIR;
      SHIR:    return m ? EX1IR : SHIR;
      EX1IR:   return m ? UPIR  : PAUIR;
      PAUIR:   return m ? EX2IR : PAUIR;
      EX2IR:   return m ? UPIR  : SHIR;
      default: return m ? SELDR : RTI;   // UPIR
    endcase
  endfunction

  always @(posedge tck) begin
    tms_log.push_back(tms);
    tdi_log.push_back(tdi);
    case (tap)
      CAPDR:   dr_sr = IDCODE;
      SHDR:    dr_sr = {tdi, dr_sr[31:1]};
      CAPIR:   ir_sr = 4'b0001;
      SHIR:    ir_sr = {tdi, ir_sr[3:1]};
      UPIR:    ir_reg = ir_sr;
      default: ;
    endcase
    tap = tap_next(tap, tms);
  end

  always @(negedge tck)
    tdo = (tap == SHDR) ? dr_sr[0] : ((tap == SHIR) ? ir_sr[0] : 1'b0);

  // ---------------- checking helpers ----------------
  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] pack_log(input bit sel_tdi);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 64; i++) begin
      if (!sel_tdi && i < tms_log.size()) v[i] = tms_log[i];
      if (sel_tdi && i < tdi_log.size()) v[i] = tdi_log[i];
    end
    return v;
  endfunction

  function automatic int ones_log(input bit sel_tdi);
    int n;
    n = 0;
    for (int i = 0; i < tms_log.size(); i++)
      n += sel_tdi ? int'(tdi_log[i]) : int'(tms_log[i]);
    return n;
  endfunction

  // Issues one command, measures accept->rsp_valid latency and captures rsp_data.
  task automatic issue(input logic [1:0] op, input logic [LEN_W-1:0] len,
                       input logic [DATA_W-1:0] data, input bit intrude);
    int w;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    check_eq("ready_before_cmd", cmd_ready, 1);
    tms_log.delete();
    tdi_log.delete();
    trst_low = 0;
    cmd_op    = op;
    cmd_len   = len;
    cmd_data  = data;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = ~op;
    cmd_len   = ~len;
    cmd_data  = ~data;
    lat = 0;
    while (!rsp_valid && lat < 1000) begin
`ifdef JTAG_HOST_TRST_EN
      if (trst_n == 1'b0) trst_low++;
`endif
      if (intrude && lat == 10) begin
        check_eq("busy_ready_low", cmd_ready, 0);
        check_eq("busy_high", busy, 1);
        cmd_valid = 1'b1;
        cmd_op    = 2'd3;
        cmd_len   = 6'd5;
      end
      if (intrude && lat == 20) cmd_valid = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq("rsp_seen", rsp_valid, 1);
    rsp = rsp_data;
    @(posedge clk);
    #1;
    check_eq("rsp_pulse_end", rsp_valid, 0);
    check_eq("ready_after", cmd_ready, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    // ---- reset state ----
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tck", tck, 0);
    check_eq("rst_tms", tms, 1);
    check_eq("rst_tdi", tdi, 0);
    check_eq("rst_ready", cmd_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_data", rsp_data, 0);
`ifdef JTAG_HOST_TRST_EN
    check_eq("rst_trst", trst_n, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
`ifdef JTAG_HOST_TRST_EN
    check_eq("trst_release", trst_n, 1);
`endif

    // ---- RESET op ----
    issue(2'd0, 6'd0, 32'h0, 1'b0);
    check_eq("reset_lat", lat, 24);
    check_eq("reset_rises", tms_log.size(), 6);
    check_eq("reset_tms", pack_log(1'b0), 64'h1F);
    check_eq("reset_tdi", pack_log(1'b1), 64'h0);
    check_eq("reset_rsp", rsp, 0);
    check_eq("reset_tap_rti", tap, RTI);
`ifdef JTAG_HOST_TRST_EN
    check_eq("reset_trst_window", trst_low, 24);
`endif

    // ---- SHIFT_IR len=4 data=0x5 ----
    issue(2'd1, 6'd4, 32'h5, 1'b0);
    check_eq("ir_lat", lat, 40);
    check_eq("ir_rises", tms_log.size(), 10);
    check_eq("ir_tms", pack_log(1'b0), 64'h183);
    check_eq("ir_tdi", pack_log(1'b1), 64'h50);
    check_eq("ir_rsp", rsp, 32'h1);
    check_eq("ir_reg", ir_reg, 4'h5);
    check_eq("ir_tap_rti", tap, RTI);
`ifdef JTAG_HOST_TRST_EN
    check_eq("ir_trst", trst_low, 0);
`endif

    // ---- SHIFT_DR len=32, second cmd_valid while busy ----
    issue(2'd2, 6'd32, 32'h0, 1'b1);
    check_eq("dr_lat", lat, 148);
    check_eq("dr_rises", tms_log.size(), 37);
    check_eq("dr_tms_ones", ones_log(1'b0), 3);
    check_eq("dr_rsp", rsp, IDCODE);
    check_eq("dr_tap_rti", tap, RTI);

    // ---- SHIFT_DR len=0 -> one bit ----
    issue(2'd2, 6'd0, 32'h0, 1'b0);
    check_eq("dr0_lat", lat, 24);
    check_eq("dr0_tms", pack_log(1'b0), 64'h19);
    check_eq("dr0_rsp", rsp, 32'h1);

    // ---- SHIFT_DR len=40 -> clamped to 32 ----
    issue(2'd2, 6'd40, 32'hFFFFFFFF, 1'b0);
    check_eq("dr40_lat", lat, 148);
    check_eq("dr40_rises", tms_log.size(), 37);
    check_eq("dr40_tdi_ones", ones_log(1'b1), 32);
    check_eq("dr40_rsp", rsp, IDCODE);

    // ---- IDLE len=0 ----
    issue(2'd3, 6'd0, 32'h0, 1'b0);
    check_eq("idle0_lat", lat, 0);
    check_eq("idle0_rises", tms_log.size(), 0);
    check_eq("idle0_rsp", rsp, 0);

    // ---- IDLE len=3 ----
    issue(2'd3, 6'd3, 32'h0, 1'b0);
    check_eq("idle3_lat", lat, 12);
    check_eq("idle3_rises", tms_log.size(), 3);
    check_eq("idle3_tms", pack_log(1'b0), 64'h0);
    check_eq("idle3_rsp", rsp, 0);

    // ---- async reset in the middle of SHIFT_DR ----
    @(negedge clk);
    cmd_op    = 2'd2;
    cmd_len   = 6'd32;
    cmd_data  = 32'h0;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (50) @(posedge clk);
    #2;
    check_eq("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_tck", tck, 0);
    check_eq("mid_rst_tms", tms, 1);
    check_eq("mid_rst_tdi", tdi, 0);
    check_eq("mid_rst_ready", cmd_ready, 1);
    check_eq("mid_rst_rsp_valid", rsp_valid, 0);
    check_eq("mid_rst_rsp_data", rsp_data, 0);
`ifdef JTAG_HOST_TRST_EN
    check_eq("mid_rst_trst", trst_n, 0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) pulses++;
    end
    check_eq("mid_no_rsp", pulses, 0);
    check_eq("mid_idle_ready", cmd_ready, 1);

    // ---- recover the TAP after the abort ----
    issue(2'd0, 6'd0, 32'h0, 1'b0);
    check_eq("rereset_lat", lat, 24);
    check_eq("rereset_tap_rti", tap, RTI);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
